// File: rtl/rr_arb8_if.sv
// Shared-line bundle between the eight requesters and the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface rr_arb8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] data;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       valid;
   logic       data_out;
   logic       timeout;

   modport slave (
      input  req, done, data,
      output gnt, sel, valid, data_out, timeout
   );

   modport master (
      output req, done, data,
      input  gnt, sel, valid, data_out, timeout
   );
endinterface

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter for a 1-bit shared line, with a hold-time limit
// and zero-dead-cycle hand-over between owners.
module rr_arb8 #(
   parameter int HOLD_MAX = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   rr_arb8_if.slave    bus
);
   localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

   typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

   state_t        r_state;
   logic [7:0]    r_gnt;
   logic [2:0]    r_sel;
   logic          r_valid;
   logic          r_timeout;
   logic [2:0]    r_last;
   logic [CW-1:0] r_hold;

   logic [2:0]    w_ptr;
   logic [3:0]    w_pick;
   logic          w_at_limit;
   logic          w_owner_req;
   logic          w_release;
   logic          w_forced;

   // Returns {found, index}; scanning from offset 8 down to 1 lets the nearest
   // requester after 'last' overwrite the farther ones, so 'last' itself ranks lowest.
   function automatic logic [3:0] f_pick(input logic [7:0] req, input logic [2:0] last);
      logic [2:0] idx;
      logic [3:0] res;
      res = 4'b0000;
      for (int i = 8; i >= 1; i--) begin
         idx = last + 3'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign w_at_limit  = (r_hold == HOLD_LAST);
   assign w_owner_req = bus.req[r_sel];
   assign w_release   = (r_state == S_GRANT) && (bus.done || !w_owner_req || w_at_limit);
   assign w_forced    = w_at_limit && !bus.done && w_owner_req;
   // On release the pointer advances to the outgoing owner in the same edge.
   assign w_ptr       = (r_state == S_GRANT) ? r_sel : r_last;
   assign w_pick      = f_pick(bus.req, w_ptr);

   // Arbitration state machine with registered grant outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= 8'h00;
         r_sel     <= 3'd0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_last    <= 3'd7;
         r_hold    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_timeout <= 1'b0;
               r_hold    <= '0;
               if (w_pick[3]) begin
                  r_state <= S_GRANT;
                  r_sel   <= w_pick[2:0];
                  r_gnt   <= 8'h01 << w_pick[2:0];
                  r_valid <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_gnt   <= 8'h00;
                  r_valid <= 1'b0;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_last    <= r_sel;
                  r_timeout <= w_forced;
                  r_hold    <= '0;
                  if (w_pick[3]) begin
                     r_state <= S_GRANT;
                     r_sel   <= w_pick[2:0];
                     r_gnt   <= 8'h01 << w_pick[2:0];
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_gnt   <= 8'h00;
                     r_valid <= 1'b0;
                  end
               end else begin
                  r_timeout <= 1'b0;
                  r_hold    <= r_hold + 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_gnt     <= 8'h00;
               r_valid   <= 1'b0;
               r_timeout <= 1'b0;
               r_hold    <= '0;
            end
         endcase
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.sel      = r_sel;
   assign bus.valid    = r_valid;
   assign bus.timeout  = r_timeout;
   assign bus.data_out = r_valid ? bus.data[r_sel] : 1'b0;
endmodule
